// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline status in, stage enables/flushes and PC enable out
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic [4:0]       dec_rs;
    logic [4:0]       dec_rt;
    logic             dec_jump;
    logic             dec_halt;
    logic             idex_dread;
    logic [4:0]       idex_wsel;
    logic             exmem_dread;
    logic             exmem_dwrite;
    logic             exmem_br_taken;
    logic             memwb_halt;
    logic             pc_en;
    logic             IF_EN;
    logic             ID_EN;
    logic             EX_EN;
    logic             MEM_EN;
    logic             IF_FLUSH;
    logic             ID_FLUSH;
    logic             EX_FLUSH;
    logic             MEM_FLUSH;
    logic             halt;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ihit, dhit, dec_rs, dec_rt, dec_jump, dec_halt, idex_dread, idex_wsel,
               exmem_dread, exmem_dwrite, exmem_br_taken, memwb_halt,
        input  pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH,
               halt, halted, stall_cycles
    );

    modport slave (
        input  ihit, dhit, dec_rs, dec_rt, dec_jump, dec_halt, idex_dread, idex_wsel,
               exmem_dread, exmem_dwrite, exmem_br_taken, memwb_halt,
        output pc_en, IF_EN, ID_EN, EX_EN, MEM_EN, IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH,
               halt, halted, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush control for the 5-stage pipeline, with data-miss wait and halt drain
module hazard_stall_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_MAX = 4
) (
    input logic               CLK,
    input logic               nRST,
    hazard_stall_ctrl_if.slave bus
);
    localparam int DW = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    drain_cnt, drain_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic             dmiss, loaduse, active;

    assign dmiss   = (bus.exmem_dread | bus.exmem_dwrite) & ~bus.dhit;
    assign loaduse = bus.idex_dread & (bus.idex_wsel != 5'd0) &
                     ((bus.idex_wsel == bus.dec_rs) | (bus.idex_wsel == bus.dec_rt));
    assign active           = (state == RUN) || (state == DWAIT);
    assign bus.halted       = (state == HALTED);
    assign bus.stall_cycles = stall_cnt;

    // State, drain counter and saturating stall counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (active && !bus.pc_en && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Hazard priority resolution, stage enable/flush outputs and next state
    always_comb begin
        state_nxt     = state;
        drain_nxt     = drain_cnt;
        bus.pc_en     = bus.ihit;
        bus.IF_EN     = 1'b1;
        bus.ID_EN     = 1'b1;
        bus.EX_EN     = 1'b1;
        bus.MEM_EN    = 1'b1;
        bus.IF_FLUSH  = 1'b0;
        bus.ID_FLUSH  = 1'b0;
        bus.EX_FLUSH  = 1'b0;
        bus.MEM_FLUSH = 1'b0;
        bus.halt      = 1'b0;
        case (state)
            RUN, DWAIT: begin
                if (dmiss) begin
                    bus.pc_en     = 1'b0;
                    bus.IF_EN     = 1'b0;
                    bus.ID_EN     = 1'b0;
                    bus.EX_EN     = 1'b0;
                    bus.MEM_EN    = 1'b0;
                    bus.MEM_FLUSH = 1'b1;
                end else if (bus.exmem_br_taken) begin
                    bus.pc_en    = 1'b1;
                    bus.IF_FLUSH = 1'b1;
                    bus.ID_FLUSH = 1'b1;
                    bus.EX_FLUSH = 1'b1;
                end else if (loaduse) begin
                    bus.pc_en    = 1'b0;
                    bus.IF_EN    = 1'b0;
                    bus.ID_FLUSH = 1'b1;
                end else if (bus.dec_jump) begin
                    bus.IF_FLUSH = 1'b1;
                end else if (!bus.ihit) begin
                    bus.pc_en    = 1'b0;
                    bus.IF_EN    = 1'b0;
                    bus.IF_FLUSH = 1'b1;
                end
                drain_nxt = '0;
                state_nxt = dmiss ? DWAIT :
                            (state == RUN && bus.dec_halt && !bus.exmem_br_taken && !loaduse) ? DRAIN :
                            RUN;
            end
            DRAIN: begin
                bus.pc_en    = 1'b0;
                bus.IF_FLUSH = 1'b1;
                bus.halt     = 1'b1;
                if (dmiss) begin
                    bus.IF_EN     = 1'b0;
                    bus.ID_EN     = 1'b0;
                    bus.EX_EN     = 1'b0;
                    bus.MEM_EN    = 1'b0;
                    bus.MEM_FLUSH = 1'b1;
                end else if (bus.exmem_br_taken) begin
                    bus.pc_en    = 1'b1;
                    bus.ID_FLUSH = 1'b1;
                    bus.EX_FLUSH = 1'b1;
                    bus.halt     = 1'b0;
                end
                drain_nxt = dmiss ? drain_cnt : drain_cnt + 1'b1;
                state_nxt = (bus.exmem_br_taken && !dmiss) ? RUN :
                            (bus.memwb_halt || drain_nxt == DW'(DRAIN_MAX)) ? HALTED :
                            DRAIN;
            end
            HALTED: begin
                bus.pc_en  = 1'b0;
                bus.IF_EN  = 1'b0;
                bus.ID_EN  = 1'b0;
                bus.EX_EN  = 1'b0;
                bus.MEM_EN = 1'b0;
                bus.halt   = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_hazard_stall_ctrl;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    logic [14:0] exq[$];
    string       tq[$];

    hazard_stall_ctrl_if #(.CNT_W(4)) bus ();
    hazard_stall_ctrl #(.CNT_W(4), .DRAIN_MAX(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic idle();
        bus.ihit = 0; bus.dhit = 0; bus.dec_rs = 0; bus.dec_rt = 0;
        bus.dec_jump = 0; bus.dec_halt = 0; bus.idex_dread = 0; bus.idex_wsel = 0;
        bus.exmem_dread = 0; bus.exmem_dwrite = 0; bus.exmem_br_taken = 0; bus.memwb_halt = 0;
    endtask

    task automatic c(input logic pc, input logic [3:0] en, input logic [3:0] fl,
                     input logic h, input logic hd, input int sc, input string tag);
        logic [3:0] s;
        s = sc[3:0];
        exq.push_back({pc, en, fl, h, hd, s});
        tq.push_back(tag);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares outputs mid-cycle against the oldest queued expectation
    always @(negedge CLK) begin
        if (exq.size() != 0) begin
            logic [14:0] e, a;
            string t;
            e = exq.pop_front();
            t = tq.pop_front();
            a = {bus.pc_en, bus.IF_EN, bus.ID_EN, bus.EX_EN, bus.MEM_EN,
                 bus.IF_FLUSH, bus.ID_FLUSH, bus.EX_FLUSH, bus.MEM_FLUSH,
                 bus.halt, bus.halted, bus.stall_cycles};
            vectors++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %b want %b (pc_en,EN[4],FLUSH[4],halt,halted,stall[4])", t, a, e);
            end
        end
    end

    initial begin
        idle();
        repeat (2) @(posedge CLK);
        #1;
        c(0, 4'b0111, 4'b1000, 0, 0, 0, "reset");
        nRST = 1;

        idle(); bus.ihit = 1;
        c(1, 4'b1111, 4'b0000, 0, 0, 0, "fetch");
        bus.idex_dread = 1; bus.idex_wsel = 5; bus.dec_rs = 5;
        c(0, 4'b0111, 4'b0100, 0, 0, 0, "loaduse_rs");
        bus.idex_wsel = 0; bus.dec_rs = 0;
        c(1, 4'b1111, 4'b0000, 0, 0, 1, "loaduse_r0");
        bus.idex_wsel = 7; bus.dec_rt = 7; bus.dec_rs = 3;
        c(0, 4'b0111, 4'b0100, 0, 0, 1, "loaduse_rt");

        idle(); bus.ihit = 1; bus.exmem_dread = 1;
        for (int i = 0; i < 3; i++) c(0, 4'b0000, 4'b0001, 0, 0, 2 + i, "dmiss");
        bus.dhit = 1;
        c(1, 4'b1111, 4'b0000, 0, 0, 5, "dhit");

        idle(); bus.exmem_br_taken = 1; bus.idex_dread = 1; bus.idex_wsel = 5; bus.dec_rs = 5;
        c(1, 4'b1111, 4'b1110, 0, 0, 5, "branch_wins");
        idle(); bus.ihit = 1; bus.dec_jump = 1;
        c(1, 4'b1111, 4'b1000, 0, 0, 5, "jump_ihit");
        bus.ihit = 0;
        c(0, 4'b1111, 4'b1000, 0, 0, 5, "jump_noihit");
        idle(); bus.ihit = 1; bus.exmem_dwrite = 1; bus.exmem_br_taken = 1;
        c(0, 4'b0000, 4'b0001, 0, 0, 6, "dmiss_over_br");
        bus.dhit = 1;
        c(1, 4'b1111, 4'b1110, 0, 0, 7, "dwait_exit_br");

        idle(); bus.ihit = 1; bus.dec_halt = 1;
        c(1, 4'b1111, 4'b0000, 0, 0, 7, "halt_decode");
        bus.dec_halt = 0;
        c(0, 4'b1111, 4'b1000, 1, 0, 7, "drain1");
        c(0, 4'b1111, 4'b1000, 1, 0, 7, "drain2");
        bus.memwb_halt = 1;
        c(0, 4'b1111, 4'b1000, 1, 0, 7, "drain3_wb");
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.ihit = i[0];
            bus.exmem_br_taken = (i == 2);
            c(0, 4'b0000, 4'b0000, 1, 1, 7, "halted");
        end

        idle(); nRST = 0;
        c(0, 4'b0111, 4'b1000, 0, 0, 0, "async_rst_halted");
        nRST = 1;

        bus.ihit = 1; bus.dec_halt = 1;
        c(1, 4'b1111, 4'b0000, 0, 0, 0, "sq_decode");
        bus.dec_halt = 0;
        c(0, 4'b1111, 4'b1000, 1, 0, 0, "sq_drain");
        bus.exmem_br_taken = 1;
        c(1, 4'b1111, 4'b1110, 0, 0, 0, "sq_branch");
        bus.exmem_br_taken = 0;
        c(1, 4'b1111, 4'b0000, 0, 0, 0, "sq_back_run");

        idle();
        for (int i = 0; i < 20; i++) c(0, 4'b0111, 4'b1000, 0, 0, (i > 15) ? 15 : i, "saturate");
        c(0, 4'b0111, 4'b1000, 0, 0, 15, "sat_hold");
        nRST = 0;
        c(0, 4'b0111, 4'b1000, 0, 0, 0, "async_rst_cnt");
        nRST = 1;

        bus.ihit = 1; bus.dec_halt = 1;
        c(1, 4'b1111, 4'b0000, 0, 0, 0, "to_decode");
        bus.dec_halt = 0;
        c(0, 4'b1111, 4'b1000, 1, 0, 0, "to_d1");
        bus.exmem_dread = 1;
        c(0, 4'b0000, 4'b1001, 1, 0, 0, "to_d2_dmiss");
        bus.exmem_dread = 0;
        for (int i = 0; i < 3; i++) c(0, 4'b1111, 4'b1000, 1, 0, 0, "to_drain");
        c(0, 4'b0000, 4'b0000, 1, 1, 0, "to_halted");

        @(posedge CLK);
        if (exq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Control-side counterpart of the 5-stage pipeline register bank. It drives the per-stage enable (IF/ID/EX/MEM _EN) and flush (_FLUSH) inputs, the `halt` flush-preserve flag and the PC enable.
- Resolves load-use hazards, instruction/data memory waits, taken branches, jumps and halt draining.
- Keeps a small state machine for data-miss wait and halt drain, plus a saturating stall-cycle counter.

Parameters:
CNT_W, 16, width of the stall-cycle counter
DRAIN_MAX, 4, maximum cycles in DRAIN before forcing HALTED

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dec_rs  in  5  rs of instruction in the IF/ID register
dec_rt  in  5  rt of instruction in the IF/ID register
dec_jump  in  1  J/JAL decoded in ID
dec_halt  in  1  HALT decoded in ID
idex_dread  in  1  load in the ID/EX register
idex_wsel  in  5  destination register of the ID/EX instruction
exmem_dread  in  1  load in the EX/MEM register
exmem_dwrite  in  1  store in the EX/MEM register
exmem_br_taken  in  1  branch/JR in EX/MEM resolved taken
memwb_halt  in  1  halt bit present in the MEM/WB register
pc_en  out  1  PC register load enable
IF_EN, ID_EN, EX_EN, MEM_EN  out  1 each  stage register enables
IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH  out  1 each  stage bubble insert
halt  out  1  keep halt bit through flushes
halted  out  1  processor stopped, sticky
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN/DWAIT

Behaviour:
- States: RUN, DWAIT, DRAIN, HALTED. Reset: state=RUN, drain_cnt=0, stall_cycles=0, halted=0.
- All other outputs are combinational from state and inputs. With all inputs 0 during reset: pc_en=0, IF_FLUSH=1, ID/EX/MEM_EN=1, all other outputs 0.
- dmiss = (exmem_dread|exmem_dwrite) & ~dhit.
- loaduse = idex_dread & (idex_wsel!=0) & (idex_wsel==dec_rs | idex_wsel==dec_rt).
- Default (all states): *_EN=1, *_FLUSH=0, pc_en=ihit, halt=0.
- Priority in RUN/DWAIT, highest first:
  1. dmiss: pc_en=0, IF/ID/EX/MEM_EN=0, MEM_FLUSH=1. ihit is ignored.
  2. exmem_br_taken: pc_en=1, IF_FLUSH=ID_FLUSH=EX_FLUSH=1.
  3. loaduse: pc_en=0, IF_EN=0, ID_FLUSH=1.
  4. dec_jump: IF_FLUSH=1, pc_en=ihit.
  5. ~ihit: pc_en=0, IF_FLUSH=1.
- Transitions:
  - RUN->DWAIT on dmiss.
  - DWAIT->RUN on dhit. Outputs that cycle are the default enables, so the memory result is captured.
  - RUN->DRAIN on dec_halt & ~dmiss & ~exmem_br_taken & ~loaduse, with drain_cnt cleared.
- DRAIN:
  - pc_en=0, IF_FLUSH=1, halt=1. ID/EX/MEM advance; dmiss freezing still applies as above.
  - drain_cnt increments on cycles without dmiss.
  - DRAIN->HALTED when memwb_halt=1 or drain_cnt==DRAIN_MAX.
  - exmem_br_taken in DRAIN (older branch squashes the halt): flushes as in RUN, halt=0, ->RUN.
- HALTED: all *_EN=0, all *_FLUSH=0, pc_en=0, halt=1, halted=1. Left only by reset.
- stall_cycles: +1 each cycle in RUN or DWAIT with pc_en=0. Saturates at all-ones; no wrap.
- Reset asserted mid-operation (any state): returns to RUN immediately and clears the counter and halted.

Test Plan:
- Load-use: idex_dread=1, idex_wsel=5, dec_rs=5, ihit=1 -> pc_en=0, IF_EN=0, ID_FLUSH=1, EX/MEM_EN=1 for one cycle; stall_cycles 0->1. Repeat with idex_wsel=0 -> no stall.
- Data miss: exmem_dread=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all EN=0 with MEM_FLUSH=1, state DWAIT; 4th cycle all EN=1 and back in RUN; stall_cycles=3.
- Taken branch with simultaneous loaduse and ~ihit -> pc_en=1, IF/ID/EX_FLUSH=1, IF_EN=1; branch wins.
- Halt drain: dec_halt=1, then memwb_halt=1 three cycles later -> halt=1 and IF_FLUSH=1 in DRAIN; halted=1 on the 4th cycle; all EN=0 thereafter despite ihit toggling.
- Halt squash: in DRAIN assert exmem_br_taken -> halt=0, flushes asserted, state RUN, halted stays 0. Separately, with memwb_halt held 0 -> HALTED after DRAIN_MAX=4 cycles.
- Saturation/reset: CNT_W=4, hold ihit=0 for 20 cycles -> stall_cycles holds at 15. Pulse nRST low asynchronously -> stall_cycles=0, state RUN, halted=0.
